modexp_stream_ctrl: RTL
=======================

# modexp_stream_ctrl

Word-serial operand/result sequencer that sits directly upstream and downstream of `ModExp`. A host loads the 4096-bit operands m, e, n, r, t (64 × 64-bit words each) and the 64-bit nprime0 into local buffers. On `go`, the block streams the operands into `ModExp` one word per cycle, waits for the exponentiation to complete, then drains the 64-word result into a host-readable buffer and pulses `done`.

## Interface
Parameters:
- `DATA_WIDTH`, 64, word width (equals `` `DATA_WIDTH ``)
- `WORDS`, 64, words per 4096-bit operand
- `AW`, 6, word address width (log2 WORDS)
- `COMPLETE_CODE`, 9, `exp_state` value that signals ModExp completion

Ports:
- `clk` in 1: single clock, all logic on posedge
- `reset` in 1: synchronous, active-high
- `wr_en` in 1: host operand write strobe
- `wr_sel` in 3: 0=m, 1=e, 2=n, 3=r, 4=t; values 5–7 are ignored
- `wr_addr` in AW: word index, word 0 = least significant
- `wr_data` in DATA_WIDTH: write data
- `np0_in` in 64: nprime0 value
- `np0_valid` in 1: latches `np0_in` and sets the internal `np0_loaded` flag
- `go` in 1: start request, level-sampled
- `rd_addr` in AW: result word index
- `rd_data` out DATA_WIDTH: result word at `rd_addr`, registered, 1-cycle latency
- `busy` out 1: high in every state except IDLE
- `done` out 1: 1-cycle pulse at end of run
- `err` out 1: 1-cycle pulse when `go` is rejected
- `m_buf`, `e_buf`, `n_buf`, `r_buf`, `t_buf` out DATA_WIDTH: streamed operand words to ModExp
- `nprime0` out 64: latched nprime0, held stable
- `startInput`, `startCompute`, `getResult` out 1: ModExp control
- `exp_state` in 5: ModExp state
- `res_out` in DATA_WIDTH: ModExp result word

## Operation
- **Storage.** Five operand buffers (WORDS × DATA_WIDTH each), one result buffer, a 7-bit word counter `cnt`, and an `np0_loaded` flag.
- **IDLE**
  - `wr_en` writes the buffer selected by `wr_sel`/`wr_addr`.
  - `np0_valid` latches nprime0 and sets `np0_loaded`.
  - On `go`:
    - If `np0_loaded` = 1: go to SEND, `cnt` <= 0, `startCompute` <= 1.
    - Otherwise: pulse `err` and stay in IDLE.
- **SEND**
  - `startInput` = 1.
  - The registered buses present word `cnt` of each operand. `cnt` increments every cycle.
  - After word 63 has been presented: `getResult` <= 1, `startInput` <= 0, go to WAIT.
- **WAIT**
  - Hold outputs until `exp_state == COMPLETE_CODE`.
  - Then go to READ with `cnt` <= 0.
- **READ**
  - Runs for 65 cycles.
  - Cycle 0 discards `res_out` to absorb ModExp's one-cycle output latency.
  - Cycle k (1..64) writes `res_out` to result word k−1.
  - After cycle 64, go to FIN.
- **FIN**
  - `done` = 1 for one cycle.
  - `startCompute` <= 0, `getResult` <= 0, go to IDLE.
- **While busy:** `wr_en`, `np0_valid` and `go` are ignored, so buffers and nprime0 are unchanged. `rd_addr` reads remain legal at all times.
- **Simultaneous events**
  - `wr_en` with an accepted `go`: the write commits, and the new word is streamed because SEND starts reading on the next cycle.
  - `np0_valid` with `go` while `np0_loaded` = 0: nprime0 latches, `go` is rejected with `err`, and the next `go` is accepted.
- **Reset**
  - Also applies mid-run: state goes to IDLE, every output goes to 0, `cnt` = 0, `np0_loaded` = 0.
  - Operand and result buffer contents are not cleared.
  - A subsequent `go` requires nprime0 to be reloaded.

## Timing
- Reset values: `busy`, `done`, `err`, `startInput`, `startCompute`, `getResult` = 0; all data buses and `rd_data` = 0.
- `go` sampled at edge T: SEND occupies cycles T+1..T+64, and word k is on the buses during cycle T+1+k.
- `getResult` rises at T+65.
- WAIT lasts N cycles, ending at the first cycle in which `exp_state == COMPLETE_CODE`.
- READ takes 65 cycles, then `done` is asserted for 1 cycle.
- Total latency from `go` to `done` = 64 + N + 65 + 1 cycles.
- `done` and `busy` de-assert together at the same edge. `go` is accepted again in the cycle after `done`.
- `rd_data` = result[`rd_addr`] one cycle after `rd_addr` is applied.
- A result word written in READ cycle k is readable one cycle later.

## Test plan
- **Reset values:** assert reset for 2 cycles → all outputs 0, `busy` = 0. Then `go` without nprime0 → `err` pulse, `busy` stays 0.
- **Full run:** load m=8, e=13, n=77 (word 0, other words 0), with r/t/nprime0 from rtMod/modInv, against real ModExp; `go` → `done`, result word 0 = 50, words 1..63 = 0.
- **Stream order:** load m word k = k+1, stub ModExp, `go` → `m_buf` = 1..64 on cycles T+1..T+64, `startInput` high exactly 64 cycles, `getResult` rises at T+65.
- **Readback alignment:** stub drives `res_out` = 0xA000+i on READ cycle i → result word j = 0xA000+j+1, and the cycle-0 value is discarded.
- **Busy protection:** `wr_en` (m word 0 = 0xFFFF) and a second `go` during WAIT → buffer unchanged, no restart, one `done` only.
- **Reset mid-run:** reset during SEND at word 20 → IDLE next cycle, outputs 0; reload nprime0, `go` → full stream restarts from word 0.

Source files
------------

// File: rtl/modexp_stream_ctrl.sv
// Word-serial operand/result sequencer around ModExp: buffers host operands,
// streams them one word per cycle, waits for completion and drains the result.
module modexp_stream_ctrl #(
    parameter int DATA_WIDTH    = 64,
    parameter int WORDS         = 64,
    parameter int AW            = 6,
    parameter int COMPLETE_CODE = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [2:0]            wr_sel,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [63:0]           np0_in,
    input  logic                  np0_valid,
    input  logic                  go,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] m_buf,
    output logic [DATA_WIDTH-1:0] e_buf,
    output logic [DATA_WIDTH-1:0] n_buf,
    output logic [DATA_WIDTH-1:0] r_buf,
    output logic [DATA_WIDTH-1:0] t_buf,
    output logic [63:0]           nprime0,
    output logic                  startInput,
    output logic                  startCompute,
    output logic                  getResult,
    input  logic [4:0]            exp_state,
    input  logic [DATA_WIDTH-1:0] res_out
);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_READ, S_FIN} state_t;

    localparam int            CW         = AW + 1;
    localparam logic [CW-1:0] LAST       = CW'(WORDS);
    localparam logic [4:0]    DONE_STATE = 5'(COMPLETE_CODE);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                np0_loaded;
    logic [DATA_WIDTH-1:0] m_mem [WORDS];
    logic [DATA_WIDTH-1:0] e_mem [WORDS];
    logic [DATA_WIDTH-1:0] n_mem [WORDS];
    logic [DATA_WIDTH-1:0] r_mem [WORDS];
    logic [DATA_WIDTH-1:0] t_mem [WORDS];
    logic [DATA_WIDTH-1:0] res_mem [WORDS];
    logic                idle, accept, res_we;
    logic [AW-1:0]       word_idx, res_idx;

    // Host strobes (wr_en, np0_valid, go) are single-cycle level samples, honoured
    // only in IDLE; there is no back-pressure, busy tells the host when to hold off.
    assign idle     = (state_q == S_IDLE);
    assign accept   = idle && go && np0_loaded;
    assign word_idx = cnt_q[AW-1:0];
    assign res_idx  = word_idx - AW'(1);
    assign res_we   = (state_q == S_READ) && (cnt_q != '0);
    assign busy     = !idle;
    assign done     = (state_q == S_FIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SEND;
                    cnt_d   = '0;
                end
            end
            // cnt runs one past the last word so the final word gets its own cycle
            S_SEND: begin
                if (cnt_q == LAST) state_d = S_WAIT;
                else               cnt_d   = cnt_q + CW'(1);
            end
            S_WAIT: begin
                if (exp_state == DONE_STATE) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end
            end
            S_READ: begin
                if (cnt_q == LAST) state_d = S_FIN;
                else               cnt_d   = cnt_q + CW'(1);
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (idle && wr_en) begin
                case (wr_sel)
                    3'd0:    m_mem[wr_addr] <= wr_data;
                    3'd1:    e_mem[wr_addr] <= wr_data;
                    3'd2:    n_mem[wr_addr] <= wr_data;
                    3'd3:    r_mem[wr_addr] <= wr_data;
                    3'd4:    t_mem[wr_addr] <= wr_data;
                    default: ;
                endcase
            end
            // READ count 0 carries ModExp's pipeline bubble, so word k-1 lands at count k
            if (res_we) res_mem[res_idx] <= res_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            np0_loaded   <= 1'b0;
            nprime0      <= '0;
            err          <= 1'b0;
            startInput   <= 1'b0;
            startCompute <= 1'b0;
            getResult    <= 1'b0;
            m_buf        <= '0;
            e_buf        <= '0;
            n_buf        <= '0;
            r_buf        <= '0;
            t_buf        <= '0;
            rd_data      <= '0;
        end else begin
            err     <= idle && go && !np0_loaded;
            rd_data <= res_mem[rd_addr];
            if (idle && np0_valid) begin
                nprime0    <= np0_in;
                np0_loaded <= 1'b1;
            end
            if (accept) startCompute <= 1'b1;
            if (state_q == S_SEND) begin
                if (cnt_q == LAST) begin
                    startInput <= 1'b0;
                    getResult  <= 1'b1;
                end else begin
                    startInput <= 1'b1;
                    m_buf      <= m_mem[word_idx];
                    e_buf      <= e_mem[word_idx];
                    n_buf      <= n_mem[word_idx];
                    r_buf      <= r_mem[word_idx];
                    t_buf      <= t_mem[word_idx];
                end
            end
            if (done) begin
                startCompute <= 1'b0;
                getResult    <= 1'b0;
            end
        end
    end

endmodule
